// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq
//   Walks a fixed 10-entry codec register table and sends each entry to an
//   external I2C write master. There is one write in flight at a time, and
//   GAP_CYCLES idle cycles follow every completed write. A NACK aborts the
//   sequence. When the macro CODEC_CFG_RETRY_EN is defined, the same entry
//   is instead retried up to MAX_RETRY times before the sequence aborts.
//
// Parameters
//   GAP_CYCLES  idle cycles between consecutive writes (1..255)
//   MAX_RETRY   NACK retries per entry when CODEC_CFG_RETRY_EN is defined (1..7)
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   one-cycle request to run the whole table
//   i2c_req    out  one-cycle pulse launching one write
//   i2c_data   out  {reg_addr[6:0], reg_val[8:0]}, held from i2c_req to i2c_done
//   i2c_done   in   one-cycle pulse, end of the current write
//   i2c_nack   in   valid with i2c_done; 1 = codec did not acknowledge
//   busy       out  sequence in progress
//   cfg_done   out  level, table completed
//   cfg_error  out  level, sequence aborted on NACK
//   entry_idx  out  current or last-attempted table entry (0..9)

module codec_cfg_seq #(
    parameter int GAP_CYCLES = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_req,
    output logic [15:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [3:0]  entry_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    localparam logic [3:0] LAST_IDX = 4'd9;
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("codec_cfg_seq: GAP_CYCLES must be in 1..255");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_retry
        $error("codec_cfg_seq: MAX_RETRY must be in 1..7");
    end

    logic [2:0] state;
    logic [7:0] gap_cnt;

`ifdef CODEC_CFG_RETRY_EN
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
    logic [2:0] retry_cnt;
    // Set when the current GAP follows a NACK, so the same entry is reloaded
    // instead of advancing.
    logic       gap_retry;
`endif

    function automatic logic [15:0] cfg_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0C00;
            4'd2:    w = 16'h0017;
            4'd3:    w = 16'h0217;
            4'd4:    w = 16'h0479;
            4'd5:    w = 16'h0679;
            4'd6:    w = 16'h0812;
            4'd7:    w = 16'h0A00;
            4'd8:    w = 16'h0E02;
            4'd9:    w = 16'h1201;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            i2c_req   <= 1'b0;
            i2c_data  <= 16'h0000;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            entry_idx <= 4'd0;
            gap_cnt   <= 8'd0;
`ifdef CODEC_CFG_RETRY_EN
            retry_cnt <= 3'd0;
            gap_retry <= 1'b0;
`endif
        end else begin
            // i2c_req is registered and asserted on the REQ->WAIT edge. This
            // places the first pulse three cycles after start is sampled.
            i2c_req <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state     <= S_LOAD;
                        entry_idx <= 4'd0;
                        busy      <= 1'b1;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
                        retry_cnt <= 3'd0;
`endif
                    end
                end

                S_LOAD: begin
                    i2c_data <= cfg_word(entry_idx);
                    state    <= S_REQ;
                end

                S_REQ: begin
                    i2c_req <= 1'b1;
                    state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (i2c_done) begin
                        if (!i2c_nack) begin
                            state   <= S_GAP;
                            gap_cnt <= 8'd0;
`ifdef CODEC_CFG_RETRY_EN
                            gap_retry <= 1'b0;
`endif
                        end else begin
`ifdef CODEC_CFG_RETRY_EN
                            if (retry_cnt < RETRY_LIMIT) begin
                                retry_cnt <= retry_cnt + 3'd1;
                                gap_retry <= 1'b1;
                                gap_cnt   <= 8'd0;
                                state     <= S_GAP;
                            end else begin
                                state     <= S_ERROR;
                                busy      <= 1'b0;
                                cfg_error <= 1'b1;
                            end
`else
                            state     <= S_ERROR;
                            busy      <= 1'b0;
                            cfg_error <= 1'b1;
`endif
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= 8'd0;
`ifdef CODEC_CFG_RETRY_EN
                        if (gap_retry) begin
                            gap_retry <= 1'b0;
                            state     <= S_LOAD;
                        end else
`endif
                        if (entry_idx == LAST_IDX) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            entry_idx <= entry_idx + 4'd1;
`ifdef CODEC_CFG_RETRY_EN
                            retry_cnt <= 3'd0;
`endif
                            state     <= S_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Self-checking bench for codec_cfg_seq. It contains a randomized I2C master
// model, a queue-based scoreboard and a table-walk reference model.
module tb_codec_cfg_seq;

    localparam int GAP  = 16;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        i2c_req;
    logic [15:0] i2c_data;
    logic        busy;
    logic        cfg_done;
    logic        cfg_error;
    logic [3:0]  entry_idx;

    codec_cfg_seq #(.GAP_CYCLES(GAP), .MAX_RETRY(MAXR)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .i2c_req   (i2c_req),
        .i2c_data  (i2c_data),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .entry_idx (entry_idx)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] TBL [10] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                                         16'h0679, 16'h0812, 16'h0A00, 16'h0E02, 16'h1201};

    typedef struct {
        logic [15:0] word;
        int          idx;
        bit          first;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   nack_mode = 0;
    int   nack_ent = 0;
    int   mute_idx = -1;
    int   force_cnt = 0;
    int   run_id = 0;

    // NACK policy: mode 0 = always ACK; mode 1 = NACK only the first attempt
    // of entry ent; mode 2 = always NACK entry ent.
    function automatic bit nack_for(int mode, int ent, int e, int att);
        if (mode == 1) return (e == ent) && (att == 0);
        if (mode == 2) return (e == ent);
        return 1'b0;
    endfunction

    function automatic int find_idx(logic [15:0] w);
        for (int i = 0; i < 10; i++) if (TBL[i] == w) return i;
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model. It walks the table up to entry `last` and applies the
    // NACK/retry rules. Each expected write goes into the scoreboard, and the
    // final outcome is returned.
    task automatic model_run(input int mode, input int ent, input int last,
                             output bit exp_err, output int exp_idx);
        bit first;
        first   = 1'b1;
        exp_err = 1'b0;
        exp_idx = 9;
        for (int e = 0; e <= last; e++) begin
            int att;
            att = 0;
            while (1) begin
                exp_q.push_back(exp_t'{word: TBL[e], idx: e, first: first});
                first = 1'b0;
                if (!nack_for(mode, ent, e, att)) break;
`ifdef CODEC_CFG_RETRY_EN
                if (att == MAXR) begin
                    exp_err = 1'b1;
                    exp_idx = e;
                    return;
                end
                att++;
`else
                exp_err = 1'b1;
                exp_idx = e;
                return;
`endif
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // I2C master model. It answers each request after a random delay and
    // applies the NACK policy. It also injects stray i2c_done pulses while no
    // write is outstanding.
    initial begin : master
        int att [10];
        bit pend;
        int cnt;
        bit pn;
        int fseen;
        int seen_run;
        int e;
        pend = 1'b0; cnt = 0; pn = 1'b0; fseen = 0; seen_run = 0;
        for (int i = 0; i < 10; i++) att[i] = 0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (run_id != seen_run) begin
                seen_run = run_id;
                for (int i = 0; i < 10; i++) att[i] = 0;
            end
            if (force_cnt != fseen) begin
                fseen = force_cnt;
                i2c_done = 1'b1;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    i2c_done = 1'b1;
                    i2c_nack = pn;
                    pend     = 1'b0;
                    done_cyc = cyc;
                end
            end else if (i2c_req === 1'b1) begin
                e = find_idx(i2c_data);
                if (e != mute_idx) begin
                    pend = 1'b1;
                    cnt  = $urandom_range(1, 5);
                    pn   = 1'b0;
                    if (e >= 0) begin
                        pn = nack_for(nack_mode, nack_ent, e, att[e]);
                        att[e]++;
                    end
                end
            end else if (mute_idx < 0 && $urandom_range(0, 7) == 0) begin
                i2c_done = 1'b1;
                i2c_nack = 1'($urandom_range(0, 1));
            end
        end
    end

    // Scoreboard monitor: every i2c_req must match the next expected write.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (i2c_req === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_i2c_req: got write 0x%04h at entry %0d, expected no write",
                         i2c_data, entry_idx);
            end else begin
                e = exp_q.pop_front();
                if (i2c_data !== e.word) begin
                    n_err++;
                    $display("FAIL i2c_data: got 0x%04h, expected 0x%04h", i2c_data, e.word);
                end
                chk("req_entry_idx", int'(entry_idx), e.idx);
                if (!e.first) chk("req_spacing_cycles", cyc - done_cyc, GAP + 3);
            end
        end
    end

    task automatic check_reset_values(string tag);
        chk({tag, ".i2c_req"},   int'(i2c_req),   0);
        chk({tag, ".i2c_data"},  int'(i2c_data),  0);
        chk({tag, ".busy"},      int'(busy),      0);
        chk({tag, ".cfg_done"},  int'(cfg_done),  0);
        chk({tag, ".cfg_error"}, int'(cfg_error), 0);
        chk({tag, ".entry_idx"}, int'(entry_idx), 0);
    endtask

    task automatic run_case(string tag, int mode, int ent, int restart_at);
        bit exp_err;
        int exp_idx;
        int lat;
        int n;
        nack_mode = mode;
        nack_ent  = ent;
        run_id++;
        model_run(mode, ent, 9, exp_err, exp_idx);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, ".busy_after_start"}, int'(busy), 1);
        lat = 1;
        while (i2c_req !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".first_req_latency"}, lat, 3);
        if (restart_at >= 0) begin
            n = 0;
            while (int'(entry_idx) != restart_at && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk({tag, ".reach_restart_entry"}, int'(entry_idx), restart_at);
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".busy_end"},  int'(busy),      0);
        chk({tag, ".cfg_done"},  int'(cfg_done),  exp_err ? 0 : 1);
        chk({tag, ".cfg_error"}, int'(cfg_error), exp_err ? 1 : 0);
        chk({tag, ".entry_idx"}, int'(entry_idx), exp_idx);
        repeat (GAP + 10) @(negedge clk);
        chk({tag, ".writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic reset_in_wait();
        bit exp_err;
        int exp_idx;
        int n;
        mute_idx  = 5;
        nack_mode = 0;
        run_id++;
        model_run(0, 0, 5, exp_err, exp_idx);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("rst_wait.entry_idx_before", int'(entry_idx), 5);
        chk("rst_wait.busy_before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check_reset_values("rst_wait");
        force_cnt++;
        repeat (GAP + 10) @(negedge clk);
        chk("rst_wait.busy_after_late_done", int'(busy), 0);
        chk("rst_wait.entry_idx_after", int'(entry_idx), 0);
        chk("rst_wait.writes_left", exp_q.size(), 0);
        exp_q.delete();
        mute_idx = -1;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_case("ack_all",        0, 0, -1);
        run_case("nack_once_e4",   1, 4, -1);
        run_case("nack_always_e2", 2, 2, -1);
        run_case("nack_once_e0",   1, 0, -1);
        run_case("restart_busy",   0, 0, 3);
        reset_in_wait();
        run_case("after_reset",    0, 0, -1);
        for (int k = 0; k < 4; k++) begin
            run_case($sformatf("rand%0d", k), $urandom_range(0, 2), $urandom_range(0, 9), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/codec_cfg_seq.md
CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Interface
REQ-001 Parameter GAP_CYCLES, 16, idle clk cycles inserted between consecutive register writes (range 1..255).
REQ-002 Parameter MAX_RETRY, 3, NACK retries allowed per table entry when retry is compiled in (range 1..7).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to run the full configuration table.
REQ-006 i2c_req  output  1  single-cycle pulse that launches one I2C write on the I2C master.
REQ-007 i2c_data  output  16  write word {reg_addr[6:0], reg_val[8:0]}; stable from i2c_req until i2c_done.
REQ-008 i2c_done  input  1  single-cycle pulse from the I2C master marking the end of one write.
REQ-009 i2c_nack  input  1  qualified by i2c_done; 1 = codec did not acknowledge.
REQ-010 busy  output  1  high from the cycle after start is accepted until DONE or ERROR is entered.
REQ-011 cfg_done  output  1  level; table completed without unrecovered NACK.
REQ-012 cfg_error  output  1  level; sequence aborted on NACK.
REQ-013 entry_idx  output  4  index of the current or last-attempted table entry.

Function
REQ-014 Fixed internal 10-entry table, sent in order: 0x1E00, 0x0C00, 0x0017, 0x0217, 0x0479, 0x0679, 0x0812, 0x0A00, 0x0E02, 0x1201.
REQ-015 States: IDLE, LOAD, REQ, WAIT, GAP, DONE, ERROR.
REQ-016 IDLE: start=1 -> LOAD, entry_idx<=0, retry count<=0, clear cfg_done and cfg_error.
REQ-017 DONE and ERROR: hold their flags; start=1 -> LOAD with the same actions as REQ-016; start ignored in every other state.
REQ-018 LOAD: i2c_data<=table[entry_idx]; -> REQ next cycle.
REQ-019 REQ: i2c_req=1 for exactly one cycle; -> WAIT.
REQ-020 WAIT: hold until i2c_done; i2c_nack=0 -> GAP; i2c_nack=1 -> handled per REQ-030/031.
REQ-021 GAP: count GAP_CYCLES cycles; then, if entry_idx==9 -> DONE, else entry_idx+1, retry count<=0, -> LOAD.
REQ-022 First i2c_req occurs exactly 3 clk cycles after the cycle in which start is sampled high.
REQ-023 i2c_done outside WAIT is ignored; at most one outstanding write.
REQ-024 entry_idx never exceeds 9; no wrap to 0 except via a new start.
REQ-025 i2c_data changes only in LOAD.

Reset
REQ-026 reset=1 forces IDLE on the next edge regardless of state, including mid-write in WAIT.
REQ-027 Reset values: i2c_req=0, i2c_data=0x0000, busy=0, cfg_done=0, cfg_error=0, entry_idx=0, retry count=0, gap counter=0.
REQ-028 reset has priority over start in the same cycle.
REQ-029 After reset, no further write issues until a new start; a late i2c_done is ignored.

Configuration
REQ-030 Macro CODEC_CFG_RETRY_EN defined: NACK with retry count < MAX_RETRY -> increment retry count, wait GAP_CYCLES, -> LOAD with the same entry; NACK with retry count == MAX_RETRY -> ERROR.
REQ-031 Macro CODEC_CFG_RETRY_EN undefined: any NACK -> ERROR immediately; retry counter is not implemented.
REQ-032 Entering ERROR sets cfg_error=1, busy=0, and keeps entry_idx at the failing entry.

Verification
REQ-033 reset, then start pulse, GAP_CYCLES=16, master always ACKs -> 10 i2c_req pulses carrying 0x1E00...0x1201 in order, then cfg_done=1, busy=0, entry_idx=9.
REQ-034 Retry enabled, NACK on the first attempt of entry 4 only -> 0x0479 is sent twice, then the sequence completes with cfg_done=1.
REQ-035 Retry enabled, entry 2 always NACKs -> 0x0017 is sent 4 times, then cfg_error=1, entry_idx=2, no further i2c_req.
REQ-036 Retry disabled, NACK on entry 0 -> cfg_error=1 after one i2c_req, entry_idx=0.
REQ-037 reset asserted while in WAIT on entry 5 -> all outputs at reset values next cycle; a following i2c_done produces no i2c_req.
REQ-038 start pulsed while busy=1 at entry 3 -> ignored: write order unchanged and exactly 10 writes issued.
